icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_if.sv | 21 ++
 rtl/icache.sv | 53 +++++
 tb/tb_icache.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and geometry for the direct-mapped instruction cache
package icache_pkg;
    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;
    typedef enum logic {IDLE, FILL} icache_state_t;
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;
    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-controller-side signals of the instruction cache
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with single-word fills and hit/miss counters
module icache
    import icache_pkg::*;
(
    input logic     CLK,
    input logic     nRST,
    icache_if.slave cif
);
    icache_state_t           state, next_state;
    icache_frame_t           frames [ICACHE_SETS];
    icachef_t                miss_addr;
    logic [ICACHE_TAG_W-1:0] req_tag;
    logic [ICACHE_IDX_W-1:0] req_idx;
    logic [31:0]             hits, misses;
    logic                    hit, miss, fill_done;

    assign req_tag   = cif.imemaddr[31:ICACHE_IDX_W+2];
    assign req_idx   = cif.imemaddr[ICACHE_IDX_W+1:2];
    assign hit       = cif.imemREN && frames[req_idx].valid && frames[req_idx].tag == req_tag;
    assign miss      = state == IDLE && cif.imemREN && !hit;
    assign fill_done = state == FILL && !cif.iwait;

    always_ff @(posedge CLK, negedge nRST)
        if (!nRST) state <= IDLE;
        else       state <= next_state;

    always_comb next_state = miss ? FILL : fill_done ? IDLE : state;

    always_comb begin
        cif.ihit       = hit;
        cif.imemload   = hit ? frames[req_idx].data : '0;
        cif.iREN       = state == FILL;
        cif.iaddr      = state == FILL ? miss_addr : '0;
        cif.hit_count  = hits;
        cif.miss_count = misses;
    end

    // Lookup stays live during FILL, so a redirect to a resident word still hits
    always_ff @(posedge CLK, negedge nRST)
        if (!nRST) begin
            miss_addr <= '0;
            hits      <= '0;
            misses    <= '0;
            for (int i = 0; i < ICACHE_SETS; i++) frames[i] <= '0;
        end else begin
            if (hit) hits <= hits + 32'd1;
            if (miss) begin
                miss_addr <= '{tag: req_tag, idx: req_idx, bytoff: 2'b00};
                misses    <= misses + 32'd1;
            end
            if (fill_done) frames[miss_addr.idx] <= '{valid: 1'b1, tag: miss_addr.tag, data: cif.iload};
        end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for the instruction cache
module tb_icache;
    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   failures = 0;

    icache_if bus ();
    icache dut (.CLK(CLK), .nRST(nRST), .cif(bus));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Miss on addr, hold iwait for waits cycles, then return data; ends in the first hit cycle
    task automatic fill(input logic [31:0] addr, input logic [31:0] data, input int waits);
        cyc();
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        #1;
        check("miss_ihit", {31'd0, bus.ihit}, 32'd0);
        check("miss_iren_idle", {31'd0, bus.iREN}, 32'd0);
        for (int k = 0; k <= waits; k++) begin
            cyc();
            bus.iwait = (k < waits);
            bus.iload = data;
            #1;
            check("fill_iren", {31'd0, bus.iREN}, 32'd1);
            check("fill_iaddr", bus.iaddr, addr);
            check("fill_ihit", {31'd0, bus.ihit}, 32'd0);
        end
        cyc();
        bus.iwait = 1'b1;
        #1;
        check("after_fill_ihit", {31'd0, bus.ihit}, 32'd1);
        check("after_fill_load", bus.imemload, data);
        check("after_fill_iren", {31'd0, bus.iREN}, 32'd0);
    endtask

    initial begin
        nRST         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.iwait    = 1'b1;
        bus.iload    = '0;
        #2;
        check("rst_ihit", {31'd0, bus.ihit}, 32'd0);
        check("rst_load", bus.imemload, 32'd0);
        check("rst_iren", {31'd0, bus.iREN}, 32'd0);
        check("rst_iaddr", bus.iaddr, 32'd0);
        check("rst_hits", bus.hit_count, 32'd0);
        check("rst_misses", bus.miss_count, 32'd0);
        #10 nRST = 1'b1;

        fill(32'h0000_0040, 32'h2001_0005, 3);
        check("cold_misses", bus.miss_count, 32'd1);
        check("cold_hits", bus.hit_count, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("repeat_ihit", {31'd0, bus.ihit}, 32'd1);
            check("repeat_iren", {31'd0, bus.iREN}, 32'd0);
        end
        cyc();
        check("repeat_hits", bus.hit_count, 32'd5);
        bus.imemREN = 1'b0;
        #1;
        check("noren_ihit", {31'd0, bus.ihit}, 32'd0);
        check("noren_load", bus.imemload, 32'd0);
        cyc();
        check("noren_hits", bus.hit_count, 32'd5);
        check("noren_misses", bus.miss_count, 32'd1);
        check("noren_iren", {31'd0, bus.iREN}, 32'd0);

        fill(32'h0000_0080, 32'hAAAA_0080, 1);
        check("conflict_misses", bus.miss_count, 32'd2);
        check("conflict_hits", bus.hit_count, 32'd5);
        fill(32'h0000_0040, 32'h2001_0005, 0);
        check("refetch_misses", bus.miss_count, 32'd3);
        check("refetch_hits", bus.hit_count, 32'd6);

        cyc();
        bus.imemaddr = 32'h0000_0100;
        #1;
        check("redir_miss", {31'd0, bus.ihit}, 32'd0);
        cyc();
        check("redir_iren", {31'd0, bus.iREN}, 32'd1);
        check("redir_iaddr", bus.iaddr, 32'h0000_0100);
        check("redir_misses", bus.miss_count, 32'd4);
        bus.imemaddr = 32'h0000_0040;
        #1;
        check("redir_ihit", {31'd0, bus.ihit}, 32'd1);
        check("redir_load", bus.imemload, 32'h2001_0005);
        check("redir_iaddr_hold", bus.iaddr, 32'h0000_0100);
        cyc();
        check("redir_hits", bus.hit_count, 32'd8);
        check("redir_still_fill", {31'd0, bus.iREN}, 32'd1);
        bus.iwait    = 1'b0;
        bus.iload    = 32'hBBBB_0100;
        bus.imemaddr = 32'h0000_0100;
        #1;
        check("redir_back_ihit", {31'd0, bus.ihit}, 32'd0);
        cyc();
        bus.iwait = 1'b1;
        #1;
        check("redir_done_ihit", {31'd0, bus.ihit}, 32'd1);
        check("redir_done_load", bus.imemload, 32'hBBBB_0100);
        check("redir_done_iren", {31'd0, bus.iREN}, 32'd0);
        check("redir_done_misses", bus.miss_count, 32'd4);

        cyc();
        check("pre_rst_hits", bus.hit_count, 32'd9);
        bus.imemaddr = 32'h0000_0080;
        cyc();
        check("rst_fill_iren", {31'd0, bus.iREN}, 32'd1);
        check("rst_fill_misses", bus.miss_count, 32'd5);
        #1 nRST = 1'b0;
        #1;
        check("async_iren", {31'd0, bus.iREN}, 32'd0);
        check("async_iaddr", bus.iaddr, 32'd0);
        check("async_hits", bus.hit_count, 32'd0);
        check("async_misses", bus.miss_count, 32'd0);
        bus.imemaddr = 32'h0000_0100;
        #1;
        check("async_cleared", {31'd0, bus.ihit}, 32'd0);
        cyc();
        nRST = 1'b1;
        #1;
        check("post_rst_ihit", {31'd0, bus.ihit}, 32'd0);
        cyc();
        check("post_rst_iren", {31'd0, bus.iREN}, 32'd1);
        check("post_rst_misses", bus.miss_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
